// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer: fetch over req/ack, decode into ALU/regfile controls, one write-back per instruction.
// Define ILLEGAL_TRAP_EN to halt on illegal instructions; otherwise they retire as NOPs.
module multicycle_seq_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        imm_signal,
  output logic        reg_write,
  output logic        pc_en,
  output logic        busy,
  output logic        fetch_err,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [3:0]  r_alu_op;
  logic        r_imm;
  logic        r_legal;
  logic [7:0]  r_wait_cnt;
  logic        r_fetch_err;
  logic        r_illegal;

  logic        w_dec_legal;
  logic [3:0]  w_dec_alu;
  logic        w_dec_imm;
  logic        w_timeout;

  assign w_timeout = (r_wait_cnt == LP_WAIT_LAST);

  // Illegal encodings leave alu_op/imm_signal at their previous values.
  always_comb begin
    w_dec_legal = 1'b0;
    w_dec_alu   = r_alu_op;
    w_dec_imm   = r_imm;
    if (r_instr[31:26] == 6'b000000) begin
      w_dec_legal = 1'b1;
      w_dec_imm   = 1'b0;
      case (r_instr[5:0])
        6'b100000: w_dec_alu = 4'b0010;
        6'b100010: w_dec_alu = 4'b0110;
        6'b100100: w_dec_alu = 4'b0000;
        6'b100101: w_dec_alu = 4'b0001;
        6'b000000: w_dec_alu = 4'b1110;
        6'b000010: w_dec_alu = 4'b1100;
        default: begin
          w_dec_legal = 1'b0;
          w_dec_alu   = r_alu_op;
          w_dec_imm   = r_imm;
        end
      endcase
    end else if (r_instr[31:26] == 6'b111111) begin
      w_dec_legal = 1'b1;
      w_dec_alu   = 4'b0010;
      w_dec_imm   = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack)       w_next = S_DECODE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        w_next = w_dec_legal ? S_EXEC : S_HALT;
`else
        w_next = S_EXEC;
`endif
      end
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = run ? S_FETCH : S_IDLE;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_alu_op    <= '0;
      r_imm       <= 1'b0;
      r_legal     <= 1'b0;
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        if (imem_ack) begin
          r_instr    <= imem_rdata;
          r_wait_cnt <= '0;
        end else if (w_timeout) begin
          r_fetch_err <= 1'b1;
          r_wait_cnt  <= '0;
        end else begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
      if (r_state == S_DECODE) begin
        r_legal  <= w_dec_legal;
        r_alu_op <= w_dec_alu;
        r_imm    <= w_dec_imm;
        if (!w_dec_legal) r_illegal <= 1'b1;
      end
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign busy       = (r_state != S_IDLE);
  assign reg_write  = (r_state == S_WB) && r_legal;
  assign pc_en      = (r_state == S_WB);
  assign instr      = r_instr;
  assign alu_op     = r_alu_op;
  assign imm_signal = r_imm;
  assign fetch_err  = r_fetch_err;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Randomized self-checking bench for multicycle_seq_ctrl with an instruction-level reference model.
// Honours ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_seq_ctrl;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [3:0]  alu_op;
  logic        imm_signal;
  logic        reg_write;
  logic        pc_en;
  logic        busy;
  logic        fetch_err;
  logic        illegal;

  multicycle_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .alu_op     (alu_op),
    .imm_signal (imm_signal),
    .reg_write  (reg_write),
    .pc_en      (pc_en),
    .busy       (busy),
    .fetch_err  (fetch_err),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, want, $time);
    end
  endfunction

  // Architectural state of the reference model
  logic [31:0] m_instr;
  logic [3:0]  m_alu;
  logic        m_imm;
  logic        m_ferr;
  logic        m_ill;

  // Expected outputs for the current cycle
  bit          ev = 1'b0;
  string       e_ph;
  logic        e_req, e_busy, e_rw, e_pc;
  logic        e_ferr, e_ill, e_imm;
  logic [31:0] e_instr;
  logic [3:0]  e_alu;

  int          wb_mode = 0;  // 0 random run, 1 run held high, 2 run held low
  bit          r_halted, r_cont;

  always @(negedge clk) begin
    if (ev && reset_n) begin
      chk({e_ph, ".imem_req"},   imem_req,   e_req);
      chk({e_ph, ".busy"},       busy,       e_busy);
      chk({e_ph, ".reg_write"},  reg_write,  e_rw);
      chk({e_ph, ".pc_en"},      pc_en,      e_pc);
      chk({e_ph, ".fetch_err"},  fetch_err,  e_ferr);
      chk({e_ph, ".illegal"},    illegal,    e_ill);
      chk({e_ph, ".instr"},      instr,      e_instr);
      chk({e_ph, ".alu_op"},     alu_op,     e_alu);
      chk({e_ph, ".imm_signal"}, imm_signal, e_imm);
    end
  end

  function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                     output logic [3:0] alu, output logic imm);
    legal = 1'b1;
    alu   = 4'b0000;
    imm   = 1'b0;
    if (w[31:26] == 6'h3F) begin
      alu = 4'b0010;
      imm = 1'b1;
    end else if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h20:   alu = 4'b0010;
        6'h22:   alu = 4'b0110;
        6'h24:   alu = 4'b0000;
        6'h25:   alu = 4'b0001;
        6'h00:   alu = 4'b1110;
        6'h02:   alu = 4'b1100;
        default: legal = 1'b0;
      endcase
    end else begin
      legal = 1'b0;
    end
  endfunction

  function automatic logic run_for_wb();
    if (wb_mode == 1) return 1'b1;
    if (wb_mode == 2) return 1'b0;
    return ($urandom_range(0, 3) != 0);
  endfunction

  function automatic logic run_mid();
    if (wb_mode == 2) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and publish the outputs this cycle must show.
  task automatic step(input string ph, input logic r, input logic a, input logic [31:0] d,
                      input logic req, input logic bsy, input logic rw, input logic pc);
    run        = r;
    imem_ack   = a;
    imem_rdata = d;
    e_ph    = ph;
    e_req   = req;
    e_busy  = bsy;
    e_rw    = rw;
    e_pc    = pc;
    e_ferr  = m_ferr;
    e_ill   = m_ill;
    e_instr = m_instr;
    e_alu   = m_alu;
    e_imm   = m_imm;
    ev      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ev       = 1'b0;
    reset_n  = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    #2;
    chk("rst.imem_req",   imem_req,   1'b0);
    chk("rst.busy",       busy,       1'b0);
    chk("rst.reg_write",  reg_write,  1'b0);
    chk("rst.pc_en",      pc_en,      1'b0);
    chk("rst.fetch_err",  fetch_err,  1'b0);
    chk("rst.illegal",    illegal,    1'b0);
    chk("rst.instr",      instr,      32'h0);
    chk("rst.alu_op",     alu_op,     4'b0000);
    chk("rst.imm_signal", imm_signal, 1'b0);
    m_instr = '0;
    m_alu   = '0;
    m_imm   = 1'b0;
    m_ferr  = 1'b0;
    m_ill   = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Idle until run is sampled high; the next cycle is the first fetch cycle.
  task automatic enter_fetch();
    logic r;
    for (int k = 0; k < 20; k++) begin
      r = (k == 19 || wb_mode == 1) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      step("idle", r, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
      if (r) break;
    end
  endtask

  // One instruction: `waits` ack-less fetch cycles before the ack (>= TO means never).
  task automatic do_instr(input logic [31:0] w, input int waits, output bit halted, output bit cont);
    bit         legal;
    logic [3:0] alu;
    logic       imm;
    logic       a;
    logic       r;
    halted = 1'b0;
    cont   = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      a = (i == waits);
      step("fetch", run_mid(), a, a ? w : $urandom, 1'b1, 1'b1, 1'b0, 1'b0);
      if (a) begin
        m_instr = w;
        break;
      end
      if (i == int'(TO) - 1) begin
        m_ferr = 1'b1;
        halted = 1'b1;
        return;
      end
    end
    ref_decode(w, legal, alu, imm);
    step("decode", run_mid(), 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    if (legal) begin
      m_alu = alu;
      m_imm = imm;
    end else begin
      m_ill = 1'b1;
    end
`ifdef ILLEGAL_TRAP_EN
    if (!legal) begin
      halted = 1'b1;
      return;
    end
`endif
    step("exec", run_mid(), 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b1, 1'b0, 1'b0);
    r = run_for_wb();
    step("wb", r, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b1, 1'(legal), 1'b1);
    cont = r;
  endtask

  task automatic recover(input bit halted, input bit cont);
    if (halted) begin
      repeat (3) step("halt", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                      1'b0, 1'b1, 1'b0, 1'b0);
      do_reset();
      enter_fetch();
    end else if (!cont) begin
      enter_fetch();
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int unsigned k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 5) begin
      w[31:26] = 6'h00;
      case ($urandom_range(0, 5))
        0: w[5:0] = 6'h20;
        1: w[5:0] = 6'h22;
        2: w[5:0] = 6'h24;
        3: w[5:0] = 6'h25;
        4: w[5:0] = 6'h00;
        default: w[5:0] = 6'h02;
      endcase
    end else if (k <= 7) begin
      w[31:26] = 6'h3F;
    end else if (k == 8) begin
      w[31:26] = 6'h00;
    end
    return w;
  endfunction

  function automatic int rand_waits();
    int unsigned k;
    k = $urandom_range(0, 99);
    if (k < 60) return 0;
    if (k < 85) return int'($urandom_range(1, 3));
    if (k < 93) return int'(TO) - int'($urandom_range(1, 2));
    return int'(TO);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fn;
    logic [3:0] want_alu;
    reset_n    = 1'b0;
    run        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    @(posedge clk);
    #1;
    do_reset();

    wb_mode = 1;
    enter_fetch();
    do_instr(32'h00221820, 0, r_halted, r_cont);
    chk("pin.add.alu_op", alu_op, 4'b0010);
    chk("pin.add.imm", imm_signal, 1'b0);
    recover(r_halted, r_cont);

    do_instr(32'hFC220005, 0, r_halted, r_cont);
    chk("pin.addi.alu_op", alu_op, 4'b0010);
    chk("pin.addi.imm", imm_signal, 1'b1);
    recover(r_halted, r_cont);

    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin fn = 6'h22; want_alu = 4'b0110; end
        1: begin fn = 6'h24; want_alu = 4'b0000; end
        2: begin fn = 6'h25; want_alu = 4'b0001; end
        3: begin fn = 6'h00; want_alu = 4'b1110; end
        default: begin fn = 6'h02; want_alu = 4'b1100; end
      endcase
      do_instr({26'h0088A40, fn}, i % 2, r_halted, r_cont);
      chk($sformatf("pin.sweep%0d.alu_op", i), alu_op, want_alu);
      chk($sformatf("pin.sweep%0d.imm", i), imm_signal, 1'b0);
      recover(r_halted, r_cont);
    end

    do_instr(32'h08000000, 0, r_halted, r_cont);
    chk("pin.illegal.flag", illegal, 1'b1);
    chk("pin.illegal.alu_kept", alu_op, 4'b1100);
`ifdef ILLEGAL_TRAP_EN
    chk("pin.illegal.halt_busy", busy, 1'b1);
    chk("pin.illegal.halt_pc_en", pc_en, 1'b0);
`else
    chk("pin.illegal.continues", r_cont, 1'b1);
`endif
    recover(r_halted, r_cont);

    do_instr(32'h00221820, int'(TO) - 1, r_halted, r_cont);
    chk("pin.late_ack.no_err", fetch_err, 1'b0);
    recover(r_halted, r_cont);

    do_instr(32'h00221820, int'(TO), r_halted, r_cont);
    chk("pin.timeout.err", fetch_err, 1'b1);
    chk("pin.timeout.busy", busy, 1'b1);
    chk("pin.timeout.req", imem_req, 1'b0);
    recover(r_halted, r_cont);

    wb_mode = 2;
    do_instr(32'h00431022, 0, r_halted, r_cont);
    chk("pin.run_drop.to_idle", r_cont, 1'b0);
    recover(r_halted, r_cont);
    wb_mode = 0;

    for (int n = 0; n < 300; n++) begin
      do_instr(rand_word(), rand_waits(), r_halted, r_cont);
      recover(r_halted, r_cont);
    end

    for (int i = 0; i < 3; i++)
      step("fetch", 1'b1, 1'b0, $urandom, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    ev      = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset.imem_req", imem_req, 1'b0);
    chk("midreset.busy", busy, 1'b0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
